register_file: RTL and testbench



---
 rtl/register_file.sv | 56 +++++
 tb/tb_register_file.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Four-entry general-purpose register file: two combinational read ports,
// one clocked write port, all entries cleared by an asynchronous reset.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic [ADDR_WIDTH-1:0] RS,
  input  logic [ADDR_WIDTH-1:0] RT,
  input  logic [ADDR_WIDTH-1:0] RD,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadRS,
  output logic [DATA_WIDTH-1:0] ReadRT,
  input  logic                  RegWrite,
  input  logic                  Clock,
  input  logic                  Reset
);

  localparam int REG_COUNT = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [REG_COUNT-1:0]  wr_sel;

  // One-hot write decode; only the addressed entry may change on an edge.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_wr_dec
      assign wr_sel[gi] = RegWrite && (RD == ADDR_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_sel[i]) begin
        regs_d[i] = WriteData;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads come straight from the stored state: no write-data bypass.
  assign ReadRS = regs_q[RS];
  assign ReadRT = regs_q[RT];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed test-plan steps followed by
// randomized writes, reads and reset pulses against an array reference model.
module tb_register_file;

  logic [1:0]  RS, RT, RD;
  logic [15:0] WriteData;
  logic [15:0] ReadRS, ReadRT;
  logic        RegWrite;
  logic        Clock;
  logic        Reset;

  logic [15:0] model [4];
  int n_checks;
  int n_fail;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut (
    .RS(RS), .RT(RT), .RD(RD), .WriteData(WriteData),
    .ReadRS(ReadRS), .ReadRT(ReadRT), .RegWrite(RegWrite),
    .Clock(Clock), .Reset(Reset)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model[i] = 16'h0;
  endtask

  // Drive write inputs away from the edge, take the rising edge, update model.
  task automatic clock_edge();
    @(posedge Clock);
    if (RegWrite && !Reset) model[RD] = WriteData;
    #1;
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rs"}, ReadRS, model[RS]);
    check({tag, "_rt"}, ReadRT, model[RT]);
  endtask

  task automatic sweep_all(input string tag);
    for (int a = 0; a < 4; a++) begin
      RS = a[1:0];
      RT = 2'(3 - a);
      #1;
      check_reads(tag);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RS = 0; RT = 0; RD = 0; WriteData = 0; RegWrite = 0;
    Reset = 1'b1;
    model_clear();
    #12;
    sweep_all("reset");
    @(negedge Clock);
    Reset = 1'b0;

    // R1=5, R2=7
    RD = 2'd1; WriteData = 16'd5; RegWrite = 1'b1;
    clock_edge();
    @(negedge Clock);
    RD = 2'd2; WriteData = 16'd7;
    clock_edge();
    @(negedge Clock);
    RegWrite = 1'b0; RS = 2'd1; RT = 2'd2;
    #1;
    check("r1_eq5", ReadRS, 16'd5);
    check("r2_eq7", ReadRT, 16'd7);

    // Disabled write leaves R1 alone
    RD = 2'd1; WriteData = 16'hFFFF;
    clock_edge();
    check("r1_hold", ReadRS, 16'd5);

    // No bypass on R3
    @(negedge Clock);
    RD = 2'd3; WriteData = 16'hA5A5; RegWrite = 1'b1; RS = 2'd3; RT = 2'd3;
    #1;
    check("r3_pre_rs", ReadRS, 16'h0000);
    check("r3_pre_rt", ReadRT, 16'h0000);
    clock_edge();
    check("r3_post_rs", ReadRS, 16'hA5A5);
    check("r3_post_rt", ReadRT, 16'hA5A5);

    // R0 writable, then async reset between edges
    @(negedge Clock);
    RD = 2'd0; WriteData = 16'h1234; RS = 2'd0;
    clock_edge();
    check("r0_write", ReadRS, 16'h1234);
    @(negedge Clock);
    RegWrite = 1'b0;
    #1;
    Reset = 1'b1;
    model_clear();
    #1;
    check("async_rst_rs", ReadRS, 16'h0000);
    sweep_all("after_rst");

    // Reset held across an edge blocks the write
    RegWrite = 1'b1; RD = 2'd2; WriteData = 16'd9;
    clock_edge();
    @(negedge Clock);
    Reset = 1'b0; RegWrite = 1'b0; RS = 2'd2;
    #1;
    check("rst_blocks_wr", ReadRS, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      @(negedge Clock);
      RD        = 2'($urandom_range(0, 3));
      WriteData = 16'($urandom);
      RegWrite  = ($urandom_range(0, 3) != 0);
      RS        = 2'($urandom_range(0, 3));
      RT        = 2'($urandom_range(0, 3));
      #1;
      check_reads("rnd_pre");
      if ($urandom_range(0, 24) == 0) begin
        Reset = 1'b1;
        model_clear();
        #1;
        check_reads("rnd_rst");
        Reset = 1'b0;
      end
      clock_edge();
      check_reads("rnd_post");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
